// File: rtl/host_buf_addr_pool.sv
// host_buf_addr_pool
//   Per-channel rings of NVMe host buffer addresses. Each backend channel
//   pushes 4 KiB aligned addresses through one-cycle strobes; the command
//   builder pops them through a registered request/acknowledge port.
//
// Ports
//   axi4_mm_clk              sole clock
//   axi4_mm_rst              synchronous active-high reset
//   host_buf_addr_avmm       per-channel 64-bit buffer address
//   host_buf_addr_valid_avmm per-channel push strobe
//   flush                    empties every ring (counters kept)
//   pop_req / pop_ch         pop request and channel select
//   pop_ack / pop_hit        one-cycle response strobe and hit qualifier
//   pop_addr                 popped address, 0 on miss
//   occupancy                entries held per channel
//   drop_cnt                 pushes lost to a full ring (saturating)
//   misalign_cnt             pushes lost to addr[11:0] != 0 (saturating)
//   debug_status             {drop[15:0], misalign[15:0], 16'b0, non-empty mask}
module host_buf_addr_pool #(
    parameter int unsigned BE_CH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CH_W  = (BE_CH > 1) ? $clog2(BE_CH) : 1,
    parameter int unsigned OCC_W = $clog2(DEPTH) + 1
) (
    input  logic                        axi4_mm_clk,
    input  logic                        axi4_mm_rst,
    input  logic [BE_CH-1:0][63:0]      host_buf_addr_avmm,
    input  logic [BE_CH-1:0]            host_buf_addr_valid_avmm,
    input  logic                        flush,
    input  logic                        pop_req,
    input  logic [CH_W-1:0]             pop_ch,
    output logic                        pop_ack,
    output logic                        pop_hit,
    output logic [63:0]                 pop_addr,
    output logic [BE_CH-1:0][OCC_W-1:0] occupancy,
    output logic [31:0]                 drop_cnt,
    output logic [31:0]                 misalign_cnt,
    output logic [63:0]                 debug_status
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [63:0]                 mem_q [BE_CH][DEPTH];
    logic [BE_CH-1:0][PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [BE_CH-1:0][OCC_W-1:0] occ_q, occ_d;
    logic [BE_CH-1:0]            push_ok, push_full, push_mis, pop_sel;
    logic                        pop_hit_d;
    logic [63:0]                 pop_addr_d;
    logic                        pop_ack_q, pop_hit_q;
    logic [63:0]                 pop_addr_q;
    logic [31:0]                 drop_q, drop_d, mis_q, mis_d;
    logic [15:0]                 nonempty;

    always_comb begin
        pop_sel    = '0;
        pop_hit_d  = 1'b0;
        pop_addr_d = '0;
        push_ok    = '0;
        push_full  = '0;
        push_mis   = '0;
        wp_d       = wp_q;
        rp_d       = rp_q;
        occ_d      = occ_q;
        nonempty   = '0;

        // An out-of-range pop_ch matches no channel and therefore misses.
        for (int unsigned i = 0; i < BE_CH; i++) begin
            if (pop_req && !flush && (32'(pop_ch) == i) && (occ_q[i] != '0)) begin
                pop_sel[i] = 1'b1;
                pop_hit_d  = 1'b1;
                pop_addr_d = mem_q[i][rp_q[i]];
            end
        end

        for (int unsigned i = 0; i < BE_CH; i++) begin
            nonempty[i] = (occ_q[i] != '0);
            if (host_buf_addr_valid_avmm[i] && !flush) begin
                // Misalignment is judged before fullness.
                if (host_buf_addr_avmm[i][11:0] != 12'h000) begin
                    push_mis[i] = 1'b1;
                end else if ((occ_q[i] == OCC_W'(DEPTH)) && !pop_sel[i]) begin
                    push_full[i] = 1'b1;
                end else begin
                    push_ok[i] = 1'b1;
                end
            end

            if (flush) begin
                wp_d[i]  = '0;
                rp_d[i]  = '0;
                occ_d[i] = '0;
            end else begin
                if (push_ok[i]) begin
                    wp_d[i] = wp_q[i] + PTR_W'(1);
                end
                if (pop_sel[i]) begin
                    rp_d[i] = rp_q[i] + PTR_W'(1);
                end
                occ_d[i] = occ_q[i] + OCC_W'(push_ok[i]) - OCC_W'(pop_sel[i]);
            end
        end

        // Several channels dropping together still count once.
        drop_d = ((|push_full) && (drop_q != 32'hFFFF_FFFF)) ? drop_q + 32'd1 : drop_q;
        mis_d  = ((|push_mis) && (mis_q != 32'hFFFF_FFFF)) ? mis_q + 32'd1 : mis_q;
    end

    always_ff @(posedge axi4_mm_clk) begin
        if (axi4_mm_rst) begin
            wp_q       <= '0;
            rp_q       <= '0;
            occ_q      <= '0;
            drop_q     <= '0;
            mis_q      <= '0;
            pop_ack_q  <= 1'b0;
            pop_hit_q  <= 1'b0;
            pop_addr_q <= '0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            occ_q      <= occ_d;
            drop_q     <= drop_d;
            mis_q      <= mis_d;
            // Every request is acknowledged, including those in a flush cycle.
            pop_ack_q  <= pop_req;
            pop_hit_q  <= pop_hit_d;
            pop_addr_q <= pop_addr_d;
        end
    end

    // Ring storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge axi4_mm_clk) begin
        for (int unsigned i = 0; i < BE_CH; i++) begin
            if (push_ok[i]) begin
                mem_q[i][wp_q[i]] <= host_buf_addr_avmm[i];
            end
        end
    end

    assign pop_ack      = pop_ack_q;
    assign pop_hit      = pop_hit_q;
    assign pop_addr     = pop_addr_q;
    assign occupancy    = occ_q;
    assign drop_cnt     = drop_q;
    assign misalign_cnt = mis_q;
    assign debug_status = {drop_q[15:0], mis_q[15:0], 16'h0000, nonempty};

endmodule
